pll_rst_seq: RTL and testbench

Lock-supervised reset sequencer that sits directly downstream of the PLL wrapper on the reference-clock domain. It drives the PLL `reset` input, watches `extlock`, and requires lock to hold for a programmable number of cycles before it releases the system reset to downstream logic. On a lock timeout it retries the PLL reset up to a bounded count, then latches a sticky failure. On loss of lock during operation it re-asserts the system reset and re-sequences the PLL.

---
 rtl/pll_rst_seq.sv | 160 ++++++++++++++++
 tb/tb_pll_rst_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// Lock-supervised PLL reset sequencer: pulses the PLL reset and waits for a stable lock, then releases sys_rst.
// Optional build macro PLL_RST_SEQ_RETRY_EN enables bounded retries on lock timeout before latching failure.
module pll_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned RETRY_MAX          = 3
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic       lol_event,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned RETRY_W = 2;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  // Out-of-range parameters are rejected at elaboration.
  if (LOCK_STABLE_CYCLES < 2 || LOCK_STABLE_CYCLES > (1 << CNT_W) ||
      LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > (1 << CNT_W) ||
      PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > (1 << CNT_W) ||
      RETRY_MAX > 3) begin : g_bad_param
    $error("pll_rst_seq: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic [1:0]           sync;
  logic                 lock_s;
  logic                 lol_nxt;
  logic                 pll_reset_nxt, sys_rst_nxt, ready_nxt, lock_fail_nxt;

  assign lock_s = sync[1];

  // State, counter, synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      sync      <= 2'b00;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_fail <= 1'b0;
      lol_event <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sync      <= {sync[0], extlock};
      pll_reset <= pll_reset_nxt;
      sys_rst   <= sys_rst_nxt;
      ready     <= ready_nxt;
      lock_fail <= lock_fail_nxt;
      lol_event <= lol_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Next state, shared counter and retry bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lol_nxt   = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
`ifdef PLL_RST_SEQ_RETRY_EN
          if (retry_cnt == RETRY_W'(RETRY_MAX)) begin
            state_nxt = S_FAIL;
          end else begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = S_PLL_RST;
            cnt_nxt   = '0;
          end
`else
          state_nxt = S_FAIL;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A lock drop here restarts the lock wait without counting as a retry.
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lol_nxt   = 1'b1;
          state_nxt = S_PLL_RST;
          cnt_nxt   = '0;
        end
      end
      S_FAIL: begin
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values are decoded from the next state so they land on the same edge.
  always_comb begin
    pll_reset_nxt = 1'b0;
    sys_rst_nxt   = 1'b1;
    ready_nxt     = 1'b0;
    lock_fail_nxt = 1'b0;
    case (state_nxt)
      S_PLL_RST: pll_reset_nxt = 1'b1;
      S_RUN: begin
        sys_rst_nxt = 1'b0;
        ready_nxt   = 1'b1;
      end
      S_FAIL:  lock_fail_nxt = 1'b1;
      default: pll_reset_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed plus randomized bench for pll_rst_seq against a deadline-based reference model.
module tb_pll_rst_seq;

  localparam int unsigned LSC  = 8;
  localparam int unsigned LT   = 32;
  localparam int unsigned PRC  = 4;
  localparam int unsigned RMAX = 2;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;

  logic       refclk = 1'b0;
  logic       reset;
  logic       extlock;
  logic       pll_reset, sys_rst, ready, lock_fail, lol_event;
  logic [1:0] retry_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase plus the cycle it was entered, and the two-stage lock delay.
  int   cyc = 0;
  int   m_phase = PH_RST;
  int   m_t0 = 0;
  int   m_retry = 0;
  logic m_lol = 1'b0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  pll_rst_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT      (LT),
    .PLL_RST_CYCLES    (PRC),
    .RETRY_MAX         (RMAX)
  ) dut (
    .refclk   (refclk),
    .reset    (reset),
    .extlock  (extlock),
    .pll_reset(pll_reset),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .lock_fail(lock_fail),
    .lol_event(lol_event),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int ph);
    m_phase = ph;
    m_t0    = cyc;
  endtask

  task automatic model_edge(input logic r, input logic x);
    int  el;
    logic ls;
    cyc++;
    ls    = m_s2;
    m_lol = 1'b0;
    if (r) begin
      go(PH_RST);
      m_retry = 0;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      el = cyc - m_t0;
      case (m_phase)
        PH_RST: if (el == int'(PRC)) go(PH_WAIT);
        PH_WAIT: begin
          if (ls) go(PH_STABLE);
          else if (el == int'(LT)) begin
`ifdef PLL_RST_SEQ_RETRY_EN
            if (m_retry == int'(RMAX)) go(PH_FAIL);
            else begin
              m_retry++;
              go(PH_RST);
            end
`else
            go(PH_FAIL);
`endif
          end
        end
        PH_STABLE: begin
          if (!ls) go(PH_WAIT);
          else if (el == int'(LSC)) begin
            go(PH_RUN);
            m_retry = 0;
          end
        end
        PH_RUN: if (!ls) begin
          m_lol = 1'b1;
          go(PH_RST);
        end
        default: ;
      endcase
      m_s2 = m_s1;
      m_s1 = x;
    end
  endtask

  task automatic check_model();
    chk("m_pll_reset", 32'(pll_reset), 32'(m_phase == PH_RST));
    chk("m_sys_rst",   32'(sys_rst),   32'(m_phase != PH_RUN));
    chk("m_ready",     32'(ready),     32'(m_phase == PH_RUN));
    chk("m_lock_fail", 32'(lock_fail), 32'(m_phase == PH_FAIL));
    chk("m_lol_event", 32'(lol_event), 32'(m_lol));
    chk("m_retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  // Drive inputs away from the edge, clock once, advance the model, then sample outputs.
  task automatic step(input logic r, input logic x);
    reset   = r;
    extlock = x;
    @(posedge refclk);
    model_edge(r, x);
    #1;
    check_model();
  endtask

  initial begin
    int n;
    int t_r1, t_r2, t_f, rmax_seen;
    int hold;
    logic v, r;

    reset   = 1'b1;
    extlock = 1'b0;

    // Reset, then release with no lock: pll_reset pulse of PRC cycles.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_sys_rst",   32'(sys_rst),   32'd1);
    chk("rst_ready",     32'(ready),     32'd0);
    chk("rst_lock_fail", 32'(lock_fail), 32'd0);
    chk("rst_lol_event", 32'(lol_event), 32'd0);
    chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    n = int'(pll_reset);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      n += int'(pll_reset);
      chk("s1_sys_rst", 32'(sys_rst), 32'd1);
    end
    chk("s1_pll_high_cycles", n, PRC);

    // Lock first sampled at edge E; ready expected from E+LSC+2.
    step(1'b0, 1'b1);
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("s2_ready_latency", n, LSC + 2);
    chk("s2_sys_rst",   32'(sys_rst),   32'd0);
    chk("s2_retry_cnt", 32'(retry_cnt), 32'd0);

    // Loss of lock in RUN sampled at F.
    step(1'b0, 1'b0);
    chk("s4_ready_f", 32'(ready), 32'd1);
    step(1'b0, 1'b0);
    chk("s4_lol_f1",   32'(lol_event), 32'd0);
    chk("s4_ready_f1", 32'(ready),     32'd1);
    step(1'b0, 1'b0);
    chk("s4_lol_f2",     32'(lol_event), 32'd1);
    chk("s4_sys_rst_f2", 32'(sys_rst),   32'd1);
    chk("s4_ready_f2",   32'(ready),     32'd0);
    chk("s4_pll_f2",     32'(pll_reset), 32'd1);
    n = 1;
    step(1'b0, 1'b0);
    chk("s4_lol_f3", 32'(lol_event), 32'd0);
    n += int'(pll_reset);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      n += int'(pll_reset);
    end
    chk("s4_pll_high_cycles", n, PRC);
    step(1'b0, 1'b1);
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("s4_ready_back", n, LSC + 2);

    // One-cycle lock glitch while stable at cnt=5: restarts without a retry.
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("s3_ready_after_glitch", n, LSC + 2);
    chk("s3_retry_cnt", 32'(retry_cnt), 32'd0);

    // Lock never arrives: retries (if enabled) then sticky failure.
    step(1'b1, 1'b0);
    t_r1 = -1; t_r2 = -1; t_f = -1; rmax_seen = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b0);
      if (retry_cnt == 2'd1 && t_r1 < 0) t_r1 = i;
      if (retry_cnt == 2'd2 && t_r2 < 0) t_r2 = i;
      if (lock_fail && t_f < 0) t_f = i;
      if (int'(retry_cnt) > rmax_seen) rmax_seen = int'(retry_cnt);
    end
`ifdef PLL_RST_SEQ_RETRY_EN
    chk("s5_retry1_time", t_r1, PRC + LT);
    chk("s5_retry2_time", t_r2, 2 * (PRC + LT));
    chk("s5_fail_time",   t_f,  3 * (PRC + LT));
    chk("s5_retry_max",   rmax_seen, RMAX);
`else
    chk("s5_fail_time", t_f, PRC + LT);
    chk("s5_retry_max", rmax_seen, 0);
`endif
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("s5_fail_sticky", 32'(lock_fail), 32'd1);
    chk("s5_fail_ready",  32'(ready),     32'd0);
    chk("s5_fail_pll",    32'(pll_reset), 32'd0);
    chk("s5_fail_sysrst", 32'(sys_rst),   32'd1);
    step(1'b1, 1'b1);
    chk("s5_reset_clears", 32'(lock_fail), 32'd0);

    // Randomized lock activity with occasional resets, checked every cycle by the model.
    for (int k = 0; k < 40; k++) begin
      hold = int'($urandom_range(1, 50));
      v    = 1'($urandom_range(0, 1));
      r    = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < hold; j++) step(r && (j == 0), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
